// File: rtl/mux_scan_serializer.sv
// -----------------------------------------------------------------------------
// mux_scan_serializer
//
// Scans an 8-bit word through an external 8:1 mux, one index per bit, and
// presents each captured mux output as one bit of a serial valid/ready stream.
// A word is accepted in IDLE, then the block alternates DRIVE (one cycle for
// the mux to settle on the new sel_out) and OUT (hold the captured bit until
// the downstream handshake) eight times before returning to IDLE.
//
// State table
//   state | meaning
//   IDLE  | waiting for a word; load_ready high
//   DRIVE | mux settling on i_out/sel_out; y_in captured at the ending edge
//   OUT   | ser_data valid, held until ser_valid && ser_ready
//
// Ports
//   clk         rising-edge clock for all state
//   rst_n       asynchronous active-low reset
//   load_valid  upstream offers load_data
//   load_data   8-bit word to scan
//   load_ready  word accepted when high (only in IDLE, registered)
//   i_out       registered word driving mux data inputs I[7:0]
//   sel_out     registered mux select
//   y_in        mux output Y (combinational from i_out/sel_out)
//   ser_valid   ser_data holds a captured bit
//   ser_data    captured bit
//   ser_ready   downstream accepts ser_data
//   frame_last  marks the 8th bit of a frame
//   parity_out  running XOR of bits captured in the current frame
//   busy        high whenever the FSM is not in IDLE
//
// Parameter
//   MSB_FIRST   0: scan sel 0..7, 1: scan sel 7..0
// -----------------------------------------------------------------------------
module mux_scan_serializer #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  output logic [7:0] i_out,
  output logic [2:0] sel_out,
  input  logic       y_in,
  output logic       ser_valid,
  output logic       ser_data,
  input  logic       ser_ready,
  output logic       frame_last,
  output logic       parity_out,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    OUT   = 2'b10
  } state_t;

  localparam logic [2:0] SEL_START = MSB_FIRST ? 3'd7 : 3'd0;

  state_t     state;
  logic [2:0] bit_cnt;

  // load_ready is registered as "next state is IDLE", so it is low for the
  // first cycle out of reset and rises on the same edge that enters IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      i_out      <= 8'd0;
      sel_out    <= 3'd0;
      ser_valid  <= 1'b0;
      ser_data   <= 1'b0;
      frame_last <= 1'b0;
      parity_out <= 1'b0;
      load_ready <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          load_ready <= 1'b1;
          busy       <= 1'b0;
          if (load_valid && load_ready) begin
            i_out      <= load_data;
            sel_out    <= SEL_START;
            bit_cnt    <= 3'd0;
            parity_out <= 1'b0;
            load_ready <= 1'b0;
            busy       <= 1'b1;
            state      <= DRIVE;
          end
        end

        DRIVE: begin
          // Mux has had one full cycle to settle on the current sel_out.
          ser_data   <= y_in;
          parity_out <= parity_out ^ y_in;
          ser_valid  <= 1'b1;
          frame_last <= (bit_cnt == 3'd7);
          state      <= OUT;
        end

        OUT: begin
          if (ser_valid && ser_ready) begin
            ser_valid <= 1'b0;
            if (bit_cnt == 3'd7) begin
              // parity_out keeps the frame parity until the next load.
              frame_last <= 1'b0;
              load_ready <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              sel_out <= MSB_FIRST ? (sel_out - 3'd1) : (sel_out + 3'd1);
              state   <= DRIVE;
            end
          end
        end

        default: begin
          // Unused encoding: drop any partial frame and return to IDLE.
          ser_valid  <= 1'b0;
          frame_last <= 1'b0;
          load_ready <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
